param_readback_tx: RTL
======================

# param_readback_tx

Serializes a snapshot of the pulse-programmer's parameter registers onto the FTDI UART line as a fixed 8N1 frame, on request. It is the transmit-direction counterpart of the parameter receive path, sitting beside `pulses` in `pulse_gen` and driving `RS232_Tx` so the host can confirm what the sequencer is running.

## Interface
- `CLKS_PER_BIT`, 104: clock cycles per UART bit (12 MHz / 115200); legal range ≥ 2.
- `clk` in 1: 12 MHz base clock; the only clock.
- `resetn` in 1: synchronous, active-high reset.
- `send` in 1: single-cycle request to transmit one frame.
- `period` in 8; `p1width`, `delay`, `p2width` in 16 each; `nut_del`, `nut_wid` in 32 each: parameter values.
- `pump`, `block` in 1 each: flag values.
- `pulse_block` in 8; `pulse_block_off` in 16; `cpmg` in 8: parameter values.
- `RS232_Tx` out 1: UART line, idle high.
- `busy` out 1: high while a frame is in flight.
- `done` out 1: single-cycle pulse when a frame completes.

## Operation
- Frame bytes, in order:
  - 0: 0xA5 sync.
  - 1: `period`.
  - 2-3: `p1width`. 4-5: `delay`. 6-7: `p2width`.
  - 8-11: `nut_del`. 12-15: `nut_wid`.
  - 16: flags `{6'b0, block, pump}`.
  - 17: `pulse_block`. 18-19: `pulse_block_off`. 20: `cpmg`.
  - 21: checksum (see Configuration).
- Multi-byte fields are sent most-significant byte first.
- On the accepted `send` edge, all inputs are snapshotted. Later input changes do not affect the frame in flight.
- Each byte is sent as 8N1: start bit 0, data LSB first, one stop bit 1. Bytes are back-to-back with no idle gap between them.
- FSM states and transitions:
  - IDLE → START when `send`=1.
  - START → DATA after `CLKS_PER_BIT` cycles.
  - DATA → STOP after 8 bits.
  - STOP → START if bytes remain; otherwise STOP → IDLE.
- Counters:
  - Bit-time counter: width `$clog2(CLKS_PER_BIT)`, counts 0..`CLKS_PER_BIT`-1 and wraps.
  - Bit index: 0..7.
  - Byte index: 0..21 (0..20 without checksum).
- `send` while `busy`=1 is ignored. It is neither queued nor able to alter the snapshot.
- Reset values: `RS232_Tx`=1, `busy`=0, `done`=0, state IDLE, all counters 0.
- Reset mid-frame aborts the frame. `RS232_Tx` is 1 from the cycle after reset is sampled, and no `done` is issued.

## Timing
- `send` sampled high in IDLE at edge N:
  - `busy`=1 and `RS232_Tx`=0 (start bit) from edge N+1.
- Each bit is held exactly `CLKS_PER_BIT` cycles.
- Frame duration is B×10×`CLKS_PER_BIT` cycles, where B = 22 (21 without checksum).
  - 22-byte frame at default: 22,880 cycles.
- The last stop bit occupies its full `CLKS_PER_BIT` cycles. On the following edge:
  - `busy` falls;
  - `done`=1 for exactly one cycle;
  - the block returns to IDLE.
- `send` coincident with the `done` cycle is accepted (IDLE). The new start bit begins the next cycle, so a new frame starts 1 cycle after the previous one ends.
- `send` and `resetn` high in the same cycle: reset wins and the request is dropped.

## Configuration
- Macro: `READBACK_CHECKSUM_EN`.
- Defined:
  - Byte 21 is appended.
  - Byte 21 = XOR of bytes 1..20 (sync excluded).
  - B = 22.
- Undefined:
  - No checksum byte and no checksum logic.
  - Frame ends after byte 20; B = 21.

## Test plan
- **Default-value readback:** drive reset and default values: period=1, p1width=30, delay=200, p2width=60, nut_del=300, nut_wid=300, pump=1, block=1, pulse_block=50, pulse_block_off=100, cpmg=4. Pulse `send` once. Required decoded bytes:
  - A5 01 00 1E 00 C8 00 3C 00 00 01 2C 00 00 01 2C 03 32 00 64 04 BA.
  - `done` fires 22,880 cycles after the first start bit.
- **Bit timing:** with `CLKS_PER_BIT`=4, measure the start-bit low period.
  - Required: exactly 4 cycles.
  - Required: byte 0x A5 observed on the line as 0,1,0,1,0,0,1,0,1,1.
- **Snapshot:** change `p1width` to 0xBEEF 10 cycles after `send`.
  - Required: bytes 2-3 remain 00 1E.
  - Required: the next frame carries BE EF.
- **Busy rejection and back-to-back:**
  - Pulse `send` mid-frame. Required: frame is unchanged and exactly one `done` occurs.
  - Pulse `send` in the `done` cycle. Required: the next start bit begins 1 cycle later.
- **Reset mid-frame:** assert `resetn` during byte 9.
  - Required: `RS232_Tx`=1 and `busy`=0 from the next cycle.
  - Required: no `done` is issued.
  - Required: a subsequent `send` yields a full correct frame.
- **Macro off:** build without `READBACK_CHECKSUM_EN`, using the default values above. Required:
  - 21 bytes, ending in 04.
  - `done` fires 21,840 cycles after the start.

Source files
------------

// File: rtl/param_readback_tx.sv
// ============================================================================
// Module   : param_readback_tx
// Purpose  : Sends a snapshot of the pulse-programmer parameters as a
//            fixed-length 8N1 UART frame. Define READBACK_CHECKSUM_EN to
//            append an XOR checksum byte.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module param_readback_tx #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        send,
    input  logic [7:0]  period,
    input  logic [15:0] p1width,
    input  logic [15:0] delay,
    input  logic [15:0] p2width,
    input  logic [31:0] nut_del,
    input  logic [31:0] nut_wid,
    input  logic        pump,
    input  logic        block,
    input  logic [7:0]  pulse_block,
    input  logic [15:0] pulse_block_off,
    input  logic [7:0]  cpmg,
    output logic        RS232_Tx,
    output logic        busy,
    output logic        done
);

    localparam int              c_CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(CLKS_PER_BIT - 1);
`ifdef READBACK_CHECKSUM_EN
    localparam logic [4:0]      c_LAST_BYTE = 5'd21;
`else
    localparam logic [4:0]      c_LAST_BYTE = 5'd20;
`endif

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_clk_cnt;
    logic [2:0]         r_bit_idx;
    logic [4:0]         r_byte_idx;
    logic               r_tx;
    logic               r_busy;
    logic               r_done;

    logic [7:0]  r_period;
    logic [15:0] r_p1width;
    logic [15:0] r_delay;
    logic [15:0] r_p2width;
    logic [31:0] r_nut_del;
    logic [31:0] r_nut_wid;
    logic [7:0]  r_flags;
    logic [7:0]  r_pulse_block;
    logic [15:0] r_pulse_block_off;
    logic [7:0]  r_cpmg;

    logic [1:0] w_state_nxt;
    logic [2:0] w_bit_nxt;
    logic [4:0] w_byte_nxt;
    logic       w_tick;
    logic       w_load;
    logic       w_done_nxt;
    logic       w_tx_nxt;
    logic [7:0] w_cur_byte;

`ifdef READBACK_CHECKSUM_EN
    logic [7:0] w_checksum;
    assign w_checksum = r_period
                      ^ r_p1width[15:8] ^ r_p1width[7:0]
                      ^ r_delay[15:8]   ^ r_delay[7:0]
                      ^ r_p2width[15:8] ^ r_p2width[7:0]
                      ^ r_nut_del[31:24] ^ r_nut_del[23:16] ^ r_nut_del[15:8] ^ r_nut_del[7:0]
                      ^ r_nut_wid[31:24] ^ r_nut_wid[23:16] ^ r_nut_wid[15:8] ^ r_nut_wid[7:0]
                      ^ r_flags ^ r_pulse_block
                      ^ r_pulse_block_off[15:8] ^ r_pulse_block_off[7:0]
                      ^ r_cpmg;
`endif

    // Byte index only changes on STOP->START, where the line carries the start bit.
    always_comb begin
        w_cur_byte = 8'h00;
        case (r_byte_idx)
            5'd0:  w_cur_byte = 8'hA5;
            5'd1:  w_cur_byte = r_period;
            5'd2:  w_cur_byte = r_p1width[15:8];
            5'd3:  w_cur_byte = r_p1width[7:0];
            5'd4:  w_cur_byte = r_delay[15:8];
            5'd5:  w_cur_byte = r_delay[7:0];
            5'd6:  w_cur_byte = r_p2width[15:8];
            5'd7:  w_cur_byte = r_p2width[7:0];
            5'd8:  w_cur_byte = r_nut_del[31:24];
            5'd9:  w_cur_byte = r_nut_del[23:16];
            5'd10: w_cur_byte = r_nut_del[15:8];
            5'd11: w_cur_byte = r_nut_del[7:0];
            5'd12: w_cur_byte = r_nut_wid[31:24];
            5'd13: w_cur_byte = r_nut_wid[23:16];
            5'd14: w_cur_byte = r_nut_wid[15:8];
            5'd15: w_cur_byte = r_nut_wid[7:0];
            5'd16: w_cur_byte = r_flags;
            5'd17: w_cur_byte = r_pulse_block;
            5'd18: w_cur_byte = r_pulse_block_off[15:8];
            5'd19: w_cur_byte = r_pulse_block_off[7:0];
            5'd20: w_cur_byte = r_cpmg;
`ifdef READBACK_CHECKSUM_EN
            5'd21: w_cur_byte = w_checksum;
`endif
            default: w_cur_byte = 8'h00;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit_idx;
        w_byte_nxt  = r_byte_idx;
        w_tick      = (r_clk_cnt == c_CNT_MAX);
        w_load      = 1'b0;
        w_done_nxt  = 1'b0;
        w_tx_nxt    = 1'b1;
        case (r_state)
            c_IDLE: begin
                if (send) begin
                    w_state_nxt = c_START;
                    w_load      = 1'b1;
                    w_bit_nxt   = 3'd0;
                    w_byte_nxt  = 5'd0;
                end
            end
            c_START: begin
                if (w_tick) begin
                    w_state_nxt = c_DATA;
                    w_bit_nxt   = 3'd0;
                end
            end
            c_DATA: begin
                if (w_tick) begin
                    if (r_bit_idx == 3'd7) w_state_nxt = c_STOP;
                    else                   w_bit_nxt   = r_bit_idx + 3'd1;
                end
            end
            c_STOP: begin
                if (w_tick) begin
                    if (r_byte_idx == c_LAST_BYTE) begin
                        w_state_nxt = c_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = c_START;
                        w_byte_nxt  = r_byte_idx + 5'd1;
                    end
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
        case (w_state_nxt)
            c_START: w_tx_nxt = 1'b0;
            c_DATA:  w_tx_nxt = w_cur_byte[w_bit_nxt];
            default: w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            r_state           <= c_IDLE;
            r_clk_cnt         <= '0;
            r_bit_idx         <= 3'd0;
            r_byte_idx        <= 5'd0;
            r_tx              <= 1'b1;
            r_busy            <= 1'b0;
            r_done            <= 1'b0;
            r_period          <= 8'h00;
            r_p1width         <= 16'h0000;
            r_delay           <= 16'h0000;
            r_p2width         <= 16'h0000;
            r_nut_del         <= 32'h0;
            r_nut_wid         <= 32'h0;
            r_flags           <= 8'h00;
            r_pulse_block     <= 8'h00;
            r_pulse_block_off <= 16'h0000;
            r_cpmg            <= 8'h00;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_idx  <= w_bit_nxt;
            r_byte_idx <= w_byte_nxt;
            r_tx       <= w_tx_nxt;
            r_busy     <= (w_state_nxt != c_IDLE);
            r_done     <= w_done_nxt;
            if (r_state == c_IDLE || w_tick) r_clk_cnt <= '0;
            else                             r_clk_cnt <= r_clk_cnt + 1'b1;
            if (w_load) begin
                r_period          <= period;
                r_p1width         <= p1width;
                r_delay           <= delay;
                r_p2width         <= p2width;
                r_nut_del         <= nut_del;
                r_nut_wid         <= nut_wid;
                r_flags           <= {6'b0, block, pump};
                r_pulse_block     <= pulse_block;
                r_pulse_block_off <= pulse_block_off;
                r_cpmg            <= cpmg;
            end
        end
    end

    assign RS232_Tx = r_tx;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

`default_nettype wire
